// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: nibble-serial adder/subtractor.
// One 4-bit ripple-carry slice is reused over NIBBLES clock cycles, least
// significant nibble first. The carry between nibbles is held in carry_r.
// Subtraction is a + ~b + 1: each B nibble is inverted and the carry seeds to 1.
// busy, done, sum, c_out and overflow all come straight from flops.

module serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   c_in,
  input  logic                   sub,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   c_out,
  output logic                   overflow
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // One full-adder cell: returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    full_add = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  logic [1:0]       state_r;
  logic [1:0]       next_state_s;
  logic [IDX_W-1:0] idx_r;
  logic             carry_r;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic             sub_r;
  logic [W-1:0]     sum_r;
  logic             c_out_r;
  logic             overflow_r;
  logic             busy_r;
  logic             done_r;

  logic             last_s;
  logic [3:0]       a_nib_s;
  logic [3:0]       b_eff_nib_s;
  logic [4:0]       chain_s;
  logic [3:0]       slice_sum_s;
  logic             overflow_s;

  assign last_s      = (idx_r == LAST_IDX);
  assign a_nib_s     = a_r[{idx_r, 2'b00} +: 4];
  assign b_eff_nib_s = b_r[{idx_r, 2'b00} +: 4] ^ {4{sub_r}};

  // The single shared 4-bit ripple-carry slice, fed by the current nibble.
  always_comb begin
    chain_s     = 5'b0_0000;
    slice_sum_s = 4'b0000;
    chain_s[0]  = carry_r;
    for (int i = 0; i < 4; i++) begin
      {chain_s[i+1], slice_sum_s[i]} = full_add(a_nib_s[i], b_eff_nib_s[i], chain_s[i]);
    end
  end

  // Signed overflow: operands share a sign and the result's sign differs.
  // Only meaningful on the last nibble, where slice bit 3 is bit W-1.
  always_comb begin
    if (a_r[W-1] == (b_r[W-1] ^ sub_r)) begin
      overflow_s = (slice_sum_s[3] != a_r[W-1]);
    end else begin
      overflow_s = 1'b0;
    end
  end

  // Next-state logic for the IDLE -> RUN -> DONE -> IDLE sequence.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = RUN;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register plus busy/done flops derived from the next state.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s != IDLE);
      done_r  <= (next_state_s == DONE);
    end
  end

  // Datapath: operand capture on start, one nibble per RUN edge.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      idx_r      <= '0;
      carry_r    <= 1'b0;
      a_r        <= '0;
      b_r        <= '0;
      sub_r      <= 1'b0;
      sum_r      <= '0;
      c_out_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r        <= a;
            b_r        <= b;
            sub_r      <= sub;
            carry_r    <= sub ? 1'b1 : c_in;
            idx_r      <= '0;
            sum_r      <= '0;
            c_out_r    <= 1'b0;
            overflow_r <= 1'b0;
          end else begin
            idx_r <= idx_r;
          end
        end
        RUN: begin
          sum_r[{idx_r, 2'b00} +: 4] <= slice_sum_s;
          carry_r                    <= chain_s[4];
          if (last_s) begin
            // Index returns to 0 rather than passing NIBBLES-1.
            idx_r      <= '0;
            c_out_r    <= chain_s[4];
            overflow_r <= overflow_s;
          end else begin
            idx_r <= idx_r + IDX_ONE;
          end
        end
        DONE: begin
          idx_r <= idx_r;
        end
        default: begin
          idx_r <= '0;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign sum      = sum_r;
  assign c_out    = c_out_r;
  assign overflow = overflow_r;

  serial_add_ctrl_chk #(
    .IDX_W    (IDX_W),
    .LAST_IDX (LAST_IDX)
  ) u_chk (
    .clk   (Clock),
    .rst_n (Resetn),
    .state (state_r),
    .idx   (idx_r),
    .busy  (busy_r),
    .done  (done_r)
  );

endmodule

// serial_add_ctrl_chk: protocol properties of the serial adder controller.
module serial_add_ctrl_chk #(
  parameter int               IDX_W    = 2,
  parameter logic [IDX_W-1:0] LAST_IDX = '1
) (
  input logic             clk,
  input logic             rst_n,
  input logic [1:0]       state,
  input logic [IDX_W-1:0] idx,
  input logic             busy,
  input logic             done
);

  a_idx_range: assert property (@(posedge clk) disable iff (!rst_n) idx <= LAST_IDX);
  a_state_legal: assert property (@(posedge clk) disable iff (!rst_n) state != 2'd3);
  a_busy_state: assert property (@(posedge clk) disable iff (!rst_n) busy == (state != 2'd0));
  a_done_busy: assert property (@(posedge clk) disable iff (!rst_n) done |-> busy);
  a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed vectors for serial_add_ctrl with NIBBLES=4.
module tb_serial_add_ctrl;

  logic        Clock;
  logic        Resetn;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        sub;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        c_out;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int exp_done = 0;

  serial_add_ctrl #(.NIBBLES(4)) dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .start    (start),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .sub      (sub),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .c_out    (c_out),
    .overflow (overflow)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Count every done pulse, sampled mid-cycle.
  always @(negedge Clock) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for done; lat = negedges seen until done, 0 if never.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge Clock);
      if (busy) busy_cnt++;
      if (done) begin
        lat = cyc;
        break;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_sum"}, 32'(sum), 32'h0000);
    check_eq({tag, "_cout"}, 32'(c_out), 32'd0);
    check_eq({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  // One operation: start pulsed for one edge, inputs scrambled while busy.
  task automatic run_op(input string tag, input logic [15:0] op_a, input logic [15:0] op_b,
                        input logic op_cin, input logic op_sub, input logic [15:0] exp_sum,
                        input logic exp_cout, input logic exp_ovf);
    int lat;
    int bc;
    @(negedge Clock);
    a = op_a; b = op_b; c_in = op_cin; sub = op_sub; start = 1'b1;
    @(posedge Clock);
    #1;
    start = 1'b0; a = ~op_a; b = ~op_b; c_in = ~op_cin; sub = ~op_sub;
    wait_done(lat, bc);
    exp_done++;
    check_eq({tag, "_latency"}, 32'(lat), 32'd5);
    check_eq({tag, "_busycycles"}, 32'(bc), 32'd5);
    check_eq({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    check_eq({tag, "_cout"}, 32'(c_out), 32'(exp_cout));
    check_eq({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    @(negedge Clock);
    check_eq({tag, "_done_low"}, 32'(done), 32'd0);
    check_eq({tag, "_busy_low"}, 32'(busy), 32'd0);
    check_eq({tag, "_sum_hold"}, 32'(sum), 32'(exp_sum));
  endtask

  initial begin
    int lat;
    int bc;
    Resetn = 1'b0; start = 1'b0; a = 16'h0000; b = 16'h0000; c_in = 1'b0; sub = 1'b0;
    #3;
    check_zero("reset_t0");
    @(negedge Clock);
    @(negedge Clock);
    Resetn = 1'b1;

    run_op("add_basic", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
    run_op("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("add_cin",   16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0);
    run_op("sub_borrow",16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_noborrow", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
    run_op("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Asynchronous reset while idle with nonzero held results.
    #2;
    Resetn = 1'b0;
    #1;
    check_zero("reset_idle");
    @(negedge Clock);
    Resetn = 1'b1;

    // start held high; operands change every busy cycle.
    @(negedge Clock);
    a = 16'h1111; b = 16'h2222; c_in = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge Clock);
    #1;
    a = 16'h5A5A; b = 16'hA5A5;
    lat = 0;
    bc = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge Clock);
      if (busy) bc++;
      if (done) begin
        lat = cyc;
        break;
      end
      a = a + 16'h0101;
      b = b ^ 16'h00FF;
    end
    exp_done++;
    check_eq("held_latency", 32'(lat), 32'd5);
    check_eq("held_busycycles", 32'(bc), 32'd5);
    check_eq("held_sum", 32'(sum), 32'h3333);
    a = 16'h4000; b = 16'h0004;
    @(negedge Clock);
    check_eq("held_gap_busy", 32'(busy), 32'd0);
    check_eq("held_gap_done", 32'(done), 32'd0);
    @(negedge Clock);
    check_eq("held_recapture", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(lat, bc);
    exp_done++;
    check_eq("held2_latency", 32'(lat), 32'd4);
    check_eq("held2_sum", 32'(sum), 32'h4004);
    @(negedge Clock);
    check_eq("held2_done_low", 32'(done), 32'd0);

    // Reset during the second RUN cycle aborts the operation.
    @(negedge Clock);
    a = 16'h1234; b = 16'h1111; c_in = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge Clock);
    #1;
    start = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    check_eq("abort_partial_sum", 32'(sum), 32'h0005);
    #2;
    Resetn = 1'b0;
    #1;
    check_zero("abort");
    repeat (6) @(negedge Clock);
    check_eq("abort_no_done", 32'(done_cnt), 32'(exp_done));
    Resetn = 1'b1;
    run_op("after_abort", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);

    @(negedge Clock);
    check_eq("done_count", 32'(done_cnt), 32'(exp_done));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the number of 4-bit slices per operand; legal range 1..16; operand width W = 4*NIBBLES.
REQ-002 Clock  input  1  single clock; all state changes on its rising edge.
REQ-003 Resetn  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 a  input  W  operand A; sampled on the start-capture edge.
REQ-006 b  input  W  operand B; sampled on the start-capture edge.
REQ-007 c_in  input  1  carry-in for add mode; sampled on the start-capture edge.
REQ-008 sub  input  1  1 = compute a - b, 0 = compute a + b + c_in; sampled on the start-capture edge.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 done  output  1  one-cycle pulse; result valid.
REQ-011 sum  output  W  registered result.
REQ-012 c_out  output  1  carry out of bit W-1.
REQ-013 overflow  output  1  two's-complement overflow of the W-bit result.

Function
REQ-014 The block SHALL contain exactly one 4-bit ripple-carry adder slice (four full-adder cells) and SHALL use it for at most one nibble per clock.
REQ-015 FSM states SHALL be IDLE, RUN and DONE.
REQ-016 IDLE with start=1 at an edge: capture a, b, c_in and sub into internal registers; clear sum, c_out and overflow to 0; clear nibble index to 0; carry register := sub ? 1 : c_in; go to RUN.
REQ-017 IDLE with start=0: hold all registers.
REQ-018 Each RUN edge: effective B nibble = b_reg[idx] XOR {4{sub_reg}}; slice adds a_reg[idx], effective B nibble and the carry register; result goes to sum[4*idx+3:4*idx]; slice carry-out goes to the carry register; idx increments.
REQ-019 The RUN edge processing idx = NIBBLES-1 SHALL also load c_out with the slice carry-out, load overflow = (a_reg[W-1] == effB[W-1]) AND (sum[W-1] != a_reg[W-1]), and go to DONE.
REQ-020 DONE SHALL assert done for exactly one cycle, then go to IDLE unconditionally on the next edge.
REQ-021 Latency: if start is captured at edge E0, done SHALL be high in the cycle following edge E(NIBBLES) and low again after edge E(NIBBLES+1).
REQ-022 start SHALL be ignored in RUN and DONE; a, b, c_in and sub changes while busy SHALL NOT affect the result.
REQ-023 If start is held high continuously, a new capture SHALL occur on the first edge in IDLE (one idle cycle between operations).
REQ-024 sum, c_out and overflow SHALL hold their values from DONE until the next start capture.
REQ-025 Intermediate sum nibbles are visible during RUN; sum is guaranteed correct only while done=1 and afterwards.
REQ-026 In sub mode, c_out=1 SHALL mean no borrow (a >= b unsigned).
REQ-027 The nibble index SHALL never exceed NIBBLES-1; for NIBBLES=1, RUN SHALL last exactly one edge.

Reset
REQ-028 Resetn low SHALL immediately force state IDLE, idx 0, carry register 0, busy 0, done 0, sum 0, c_out 0 and overflow 0, independent of Clock.
REQ-029 Reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse; the first start after Resetn deasserts SHALL begin a fresh operation.

Verification (NIBBLES=4)
REQ-030 Resetn low at any time -> busy=0, done=0, sum=0x0000, c_out=0, overflow=0 with no clock edge.
REQ-031 a=0x1234, b=0x0FFF, c_in=0, sub=0, start one cycle -> done high exactly after the 4th following edge; sum=0x2233, c_out=0, overflow=0; busy high for 5 cycles.
REQ-032 a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1, overflow=0. a=0x7FFF, b=0x0001 -> sum=0x8000, c_out=0, overflow=1.
REQ-033 sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, c_out=0, overflow=0. sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, c_out=1, overflow=1.
REQ-034 start held high with a and b changed every cycle while busy -> result matches the operands captured at the first edge; next capture occurs one cycle after done; no done pulse is missed or duplicated.
REQ-035 Resetn pulsed low during the 2nd RUN cycle -> outputs zero immediately, no done pulse; the next start with a=0x0001, b=0x0002 -> sum=0x0003.
